// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec -- execute-stage ALU for Osiris I
//
// Purpose:
//   Executes the 5-bit ALU control code on two operands and registers the
//   result and a branch/compare condition for the EX/MEM stage. Shifts run
//   bit-serially (1 bit per cycle) by default. In that mode the block stalls
//   upstream through o_ready while a shift is in flight.
//
// Configuration:
//   BARREL_SHIFT_EN -- when defined, shifts use a combinational barrel shifter.
//                      Every code then completes in one cycle and o_ready is
//                      tied high. The SHIFT state, counter and shift register
//                      are not built in that case.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     request valid
//   o_ready     request accepted this cycle when high (IDLE state)
//   i_alu_ctrl  operation code
//   i_src_a     operand A
//   i_src_b     operand B; the low $clog2(DATA_WIDTH) bits are the shift amount
//   i_flush     synchronous abort, highest priority
//   o_valid     one-cycle pulse, result fields valid
//   o_result    result (held while o_valid is low)
//   o_cond      branch/compare condition (held while o_valid is low)
//   o_illegal   an unknown code was accepted (held while o_valid is low)
//
// Handshake: a request transfers on a rising edge where i_valid and o_ready
// are both high. Upstream keeps the request stable until it transfers.
// o_ready depends only on state. The response is a single o_valid pulse with
// no back-pressure.
// -----------------------------------------------------------------------------
module alu_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [4:0]            i_alu_ctrl,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_cond,
    output logic                  o_illegal
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SLTU = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_BNE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BLTU = 5'b01101;
    localparam logic [4:0] OP_BGE  = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;

`ifndef BARREL_SHIFT_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
    typedef enum logic [1:0] {SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2} sh_op_e;
`endif

    logic [SHW-1:0]        shamt;
    logic                  lt_s;
    logic                  lt_u;
    logic [DATA_WIDTH-1:0] dec_res;
    logic                  dec_cond;
    logic                  dec_illegal;

    logic                  valid_d,   valid_q;
    logic [DATA_WIDTH-1:0] result_d,  result_q;
    logic                  cond_d,    cond_q;
    logic                  illegal_d, illegal_q;

`ifndef BARREL_SHIFT_EN
    logic                  dec_is_shift;
    sh_op_e                dec_sh_op;
    state_e                state_d,   state_q;
    logic [SHW-1:0]        cnt_d,     cnt_q;
    logic [DATA_WIDTH-1:0] shreg_d,   shreg_q;
    sh_op_e                sh_op_d,   sh_op_q;
`endif

    assign shamt = i_src_b[SHW-1:0];
    assign lt_s  = $signed(i_src_a) < $signed(i_src_b);
    assign lt_u  = i_src_a < i_src_b;

    // Single-cycle decode. Unknown codes fall through to default, which also
    // catches X/Z codes in four-state simulation.
    always_comb begin
        dec_res     = '0;
        dec_cond    = 1'b0;
        dec_illegal = 1'b0;
`ifndef BARREL_SHIFT_EN
        dec_is_shift = 1'b0;
        dec_sh_op    = SH_SLL;
`endif
        case (i_alu_ctrl)
            OP_AND:  dec_res = i_src_a & i_src_b;
            OP_OR:   dec_res = i_src_a | i_src_b;
            OP_XOR:  dec_res = i_src_a ^ i_src_b;
            OP_ADD:  dec_res = i_src_a + i_src_b;
            OP_SUB:  dec_res = i_src_a - i_src_b;
`ifdef BARREL_SHIFT_EN
            OP_SLL:  dec_res = i_src_a << shamt;
            OP_SRL:  dec_res = i_src_a >> shamt;
            OP_SRA:  dec_res = $signed(i_src_a) >>> shamt;
`else
            OP_SLL:  begin dec_is_shift = 1'b1; dec_sh_op = SH_SLL; end
            OP_SRL:  begin dec_is_shift = 1'b1; dec_sh_op = SH_SRL; end
            OP_SRA:  begin dec_is_shift = 1'b1; dec_sh_op = SH_SRA; end
`endif
            OP_SLT:  dec_cond = lt_s;
            OP_SLTU: dec_cond = lt_u;
            OP_BEQ:  dec_cond = (i_src_a == i_src_b);
            OP_BNE:  dec_cond = (i_src_a != i_src_b);
            OP_BLT:  dec_cond = lt_s;
            OP_BLTU: dec_cond = lt_u;
            OP_BGE:  dec_cond = !lt_s;
            OP_BGEU: dec_cond = !lt_u;
            default: dec_illegal = 1'b1;
        endcase
        // Compare and branch codes return the condition as a 0/1 word.
        if (i_alu_ctrl >= OP_SLT && i_alu_ctrl <= OP_BGEU && i_alu_ctrl != OP_SRA) begin
            dec_res = {{(DATA_WIDTH-1){1'b0}}, dec_cond};
        end
    end

`ifdef BARREL_SHIFT_EN
    assign o_ready = 1'b1;

    always_comb begin
        valid_d   = 1'b0;
        result_d  = result_q;
        cond_d    = cond_q;
        illegal_d = illegal_q;
        // Flush drops a simultaneous request.
        if (!i_flush && i_valid) begin
            valid_d   = 1'b1;
            result_d  = dec_res;
            cond_d    = dec_cond;
            illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            cond_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_d;
            cond_q    <= cond_d;
            illegal_q <= illegal_d;
        end
    end
`else
    assign o_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        sh_op_d   = sh_op_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        cond_d    = cond_q;
        illegal_d = illegal_q;
        if (i_flush) begin
            // Abort: any in-flight shift and any simultaneous request are dropped.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (dec_is_shift) begin
                            state_d = ST_SHIFT;
                            shreg_d = i_src_a;
                            cnt_d   = shamt;
                            sh_op_d = dec_sh_op;
                        end else begin
                            valid_d   = 1'b1;
                            result_d  = dec_res;
                            cond_d    = dec_cond;
                            illegal_d = dec_illegal;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        case (sh_op_q)
                            SH_SRL:  shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                            SH_SRA:  shreg_d = {shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};
                            default: shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        endcase
                        cnt_d = cnt_q - SHW'(1);
                    end else begin
                        state_d   = ST_IDLE;
                        valid_d   = 1'b1;
                        result_d  = shreg_q;
                        cond_d    = 1'b0;
                        illegal_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            sh_op_q   <= SH_SLL;
            valid_q   <= 1'b0;
            result_q  <= '0;
            cond_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            sh_op_q   <= sh_op_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            cond_q    <= cond_d;
            illegal_q <= illegal_d;
        end
    end
`endif

    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_cond    = cond_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec (DATA_WIDTH = 32)
// Directed vector table, hand-written abort sequences, and random operations
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_exec;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_alu_ctrl;
    logic [31:0] i_src_a;
    logic [31:0] i_src_b;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_cond;
    logic        o_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        string       nm;
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cond;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    alu_exec #(.DATA_WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_alu_ctrl (i_alu_ctrl),
        .i_src_a    (i_src_a),
        .i_src_b    (i_src_b),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_cond     (o_cond),
        .o_illegal  (o_illegal)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 3000000");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    endtask

    function automatic bit is_shift(input logic [4:0] c);
        return (c == 5'd5) || (c == 5'd6) || (c == 5'd9);
    endfunction

    // Reference model from the operation definitions, using 64-bit arithmetic.
    function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic cnd, output logic ill);
        longint sa, sb, ua, ub, p, q;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sh = int'(b[4:0]);
        p  = 64'sd1 << sh;
        r = '0; cnd = 1'b0; ill = 1'b0;
        case (c)
            5'd0:  r = a & b;
            5'd1:  r = a | b;
            5'd2:  r = a ^ b;
            5'd3:  r = 32'(ua + ub);
            5'd4:  r = 32'(ua - ub);
            5'd5:  r = 32'(ua * p);
            5'd6:  r = 32'(ua / p);
            5'd9:  begin
                q = sa / p;
                if (sa < 0 && q * p != sa) q = q - 1;
                r = 32'(q);
            end
            5'd7:  begin cnd = sa < sb;  r = 32'(cnd); end
            5'd8:  begin cnd = ua < ub;  r = 32'(cnd); end
            5'd10: begin cnd = ua == ub; r = 32'(cnd); end
            5'd11: begin cnd = ua != ub; r = 32'(cnd); end
            5'd12: begin cnd = sa < sb;  r = 32'(cnd); end
            5'd13: begin cnd = ua < ub;  r = 32'(cnd); end
            5'd14: begin cnd = sa >= sb; r = 32'(cnd); end
            5'd15: begin cnd = ua >= ub; r = 32'(cnd); end
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic vec_t mk(input string nm, input logic [4:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] r, input logic cnd,
                                input logic ill);
        vec_t v;
        v.nm = nm; v.ctrl = c; v.a = a; v.b = b; v.res = r; v.cond = cnd; v.ill = ill;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the block idle. Issues one request, waits for
    // the response and checks result, flags, latency, stall length and hold.
    task automatic run_op(input string nm, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ec,
                          input logic ei);
        int  exp_lat, exp_rl, lat, rl;
        bit  got;
        logic [31:0] exp_r;
`ifdef BARREL_SHIFT_EN
        exp_rl = 0;
`else
        exp_rl = is_shift(c) ? int'(b[4:0]) + 1 : 0;
`endif
        exp_lat = exp_rl + 1;
        exp_q.push_back(er);
        i_alu_ctrl = c; i_src_a = a; i_src_b = b; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 0; rl = 0; got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            lat++;
            if (o_valid) begin got = 1'b1; break; end
            if (!o_ready) rl++;
            @(negedge i_clk);
        end
        exp_r = exp_q.pop_front();
        check({nm, "_valid_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({nm, "_result"}, o_result, exp_r);
            check({nm, "_cond"}, 32'(o_cond), 32'(ec));
            check({nm, "_illegal"}, 32'(o_illegal), 32'(ei));
            check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
            check({nm, "_ready_low"}, 32'(rl), 32'(exp_rl));
            @(negedge i_clk);
            check({nm, "_pulse_end"}, 32'(o_valid), 32'd0);
            check({nm, "_hold"}, o_result, exp_r);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] er, prev;
        logic ec, ei;
        bit saw;
        logic [4:0] c;
        logic [31:0] a, b;

        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
        i_alu_ctrl = '0; i_src_a = '0; i_src_b = '0;

        vecs.push_back(mk("add_5_7",    5'd3,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0));
        vecs.push_back(mk("sub_3_5",    5'd4,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0));
        vecs.push_back(mk("and",        5'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0));
        vecs.push_back(mk("or",         5'd1,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0));
        vecs.push_back(mk("xor",        5'd2,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0));
        vecs.push_back(mk("add_wrap",   5'd3,  32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1'b0));
        vecs.push_back(mk("slt_neg",    5'd7,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0));
        vecs.push_back(mk("sltu_neg",   5'd8,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0));
        vecs.push_back(mk("sra_4",      5'd9,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0));
        vecs.push_back(mk("sll_0",      5'd5,  32'h00001234, 32'd0,        32'h00001234, 1'b0, 1'b0));
        vecs.push_back(mk("srl_31",     5'd6,  32'hFFFFFFFF, 32'd31,       32'h00000001, 1'b0, 1'b0));
        vecs.push_back(mk("sll_31",     5'd5,  32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0));
        vecs.push_back(mk("sll_hi_b",   5'd5,  32'd1,        32'hFFFFFF23, 32'd8,        1'b0, 1'b0));
        vecs.push_back(mk("beq_9_9",    5'd10, 32'd9,        32'd9,        32'd1,        1'b1, 1'b0));
        vecs.push_back(mk("bne_3_4",    5'd11, 32'd3,        32'd4,        32'd1,        1'b1, 1'b0));
        vecs.push_back(mk("blt",        5'd12, 32'hFFFFFFFE, 32'd3,        32'd1,        1'b1, 1'b0));
        vecs.push_back(mk("bltu",       5'd13, 32'hFFFFFFFE, 32'd3,        32'd0,        1'b0, 1'b0));
        vecs.push_back(mk("bgeu",       5'd15, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0));
        vecs.push_back(mk("bge",        5'd14, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b1, 1'b0));
        vecs.push_back(mk("illegal_16", 5'd16, 32'd7,        32'd9,        32'd0,        1'b0, 1'b1));
        vecs.push_back(mk("after_ill",  5'd3,  32'd1,        32'd1,        32'd2,        1'b0, 1'b0));

        // Reset state, checked while reset is asserted.
        #3;
        check("rst_ready",   32'(o_ready),   32'd1);
        check("rst_valid",   32'(o_valid),   32'd0);
        check("rst_result",  o_result,       32'd0);
        check("rst_cond",    32'(o_cond),    32'd0);
        check("rst_illegal", 32'(o_illegal), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("post_rst_ready", 32'(o_ready), 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].nm, vecs[i].ctrl, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].cond, vecs[i].ill);
        end

        // Flush with a simultaneous request drops it; outputs hold.
        prev = 32'd2;
        i_alu_ctrl = 5'd3; i_src_a = 32'd7; i_src_b = 32'd8; i_valid = 1'b1; i_flush = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0; i_flush = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o_valid) saw = 1'b1;
            @(negedge i_clk);
        end
        check("flush_accept_no_valid", 32'(saw), 32'd0);
        check("flush_accept_hold", o_result, prev);

`ifndef BARREL_SHIFT_EN
        // SLL by 20 flushed at cycle 3: no response, ready next cycle.
        i_alu_ctrl = 5'd5; i_src_a = 32'd1; i_src_b = 32'd20; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (o_valid) saw = 1'b1;
            @(negedge i_clk);
        end
        i_flush = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_ready_next", 32'(o_ready), 32'd1);
        for (int k = 0; k < 25; k++) begin
            if (o_valid) saw = 1'b1;
            @(negedge i_clk);
        end
        check("flush_no_valid", 32'(saw), 32'd0);
`endif
        run_op("add_after_flush", 5'd3, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

        // Request held during a shift is taken only once the block is idle.
        model(5'd6, 32'hF0000000, 32'd6, er, ec, ei);
        exp_q.push_back(er);
        exp_q.push_back(32'd5);
        i_alu_ctrl = 5'd6; i_src_a = 32'hF0000000; i_src_b = 32'd6; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_alu_ctrl = 5'd3; i_src_a = 32'd2; i_src_b = 32'd3;
        saw = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (o_valid && !saw) begin
                saw = 1'b1;
                check("held_first_result", o_result, exp_q.pop_front());
            end
            if (o_ready) break;
            @(negedge i_clk);
        end
        if (!saw) void'(exp_q.pop_front());
        check("held_first_seen", 32'(saw), 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("held_second_valid", 32'(o_valid), 32'd1);
        check("held_second_result", o_result, exp_q.pop_front());
        @(negedge i_clk);
        check("held_once_only", 32'(o_valid), 32'd0);

        // Asynchronous reset in the middle of a long shift.
        run_op("pre_reset_add", 5'd3, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        i_alu_ctrl = 5'd6; i_src_a = 32'hFFFFFFFF; i_src_b = 32'd30; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("midrst_result", o_result,        32'd0);
        check("midrst_valid",  32'(o_valid),    32'd0);
        check("midrst_ready",  32'(o_ready),    32'd1);
        check("midrst_cond",   32'(o_cond),     32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge i_clk);
            if (o_valid) saw = 1'b1;
        end
        check("midrst_no_late_valid", 32'(saw), 32'd0);
        run_op("add_after_rst", 5'd3, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        // Random operations against the reference model.
        for (int n = 0; n < 200; n++) begin
            c = 5'($urandom_range(0, 31));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            model(c, a, b, er, ec, ei);
            run_op($sformatf("rand%0d_op%0d", n, c), c, a, b, er, ec, ei);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
